// File: rtl/alu_input_sequencer.sv
// alu_input_sequencer
// Front end for the 8-bit ALU select stage. Successive presses of the enter
// button load operand A, operand B and a 4-bit opcode from the switches.
// The ALU result is then captured into a held register for display.
// Completed operations are counted, and opcodes with no ALU function
// (4'hD, 4'hE) are flagged.
//
// Optional feature macro: ALU_CHAIN_EN
//   When defined, a press in SHOW copies the held result into operand A and
//   goes straight to LOAD_B, so that results chain into the next operation.
//   When undefined, a press in SHOW returns to LOAD_A and A is left as is.
module alu_input_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sw,
    input  logic       enter,
    input  logic [7:0] alu_x,
    output logic [7:0] a_out,
    output logic [7:0] b_out,
    output logic [3:0] sel_out,
    output logic [7:0] result,
    output logic [2:0] stage,
    output logic       done,
    output logic       bad_op,
    output logic [7:0] op_count
);

    // State encodings are visible on the LEDs, so they are fixed values
    localparam logic [2:0] ST_LOAD_A  = 3'd0;
    localparam logic [2:0] ST_LOAD_B  = 3'd1;
    localparam logic [2:0] ST_LOAD_OP = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_SHOW    = 3'd4;

    logic [2:0] state_reg;
    logic [2:0] state_next;
    logic       enter_q_reg;
    logic       press;

    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic [3:0] sel_reg;
    logic [7:0] result_reg;
    logic       bad_op_reg;
    logic [7:0] op_count_reg;

    // A single rising edge of enter is one press, however long it is held
    assign press = enter & ~enter_q_reg;

    // Previous enter level, used for the rising-edge detector
    always_ff @(posedge clk) begin
        if (reset) begin
            enter_q_reg <= 1'b0;
        end else begin
            enter_q_reg <= enter;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_LOAD_A;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: EXEC advances on its own; every other state waits for a press
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LOAD_A:  if (press) state_next = ST_LOAD_B;
            ST_LOAD_B:  if (press) state_next = ST_LOAD_OP;
            ST_LOAD_OP: if (press) state_next = ST_EXEC;
            ST_EXEC:    state_next = ST_SHOW;
            ST_SHOW: begin
                if (press) begin
`ifdef ALU_CHAIN_EN
                    state_next = ST_LOAD_B;
`else
                    state_next = ST_LOAD_A;
`endif
                end
            end
            // Encodings 5-7 are never entered normally; recover to LOAD_A
            default:    state_next = ST_LOAD_A;
        endcase
    end

    // Output decode: done is a pure decode of SHOW, with no register of its own
    always_comb begin
        done  = (state_reg == ST_SHOW);
        stage = state_reg;
    end

    // Datapath registers: switches are sampled only on a press in the matching state
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg        <= 8'h00;
            b_reg        <= 8'h00;
            sel_reg      <= 4'h0;
            result_reg   <= 8'h00;
            bad_op_reg   <= 1'b0;
            op_count_reg <= 8'h00;
        end else begin
            case (state_reg)
                ST_LOAD_A: begin
                    if (press) a_reg <= sw;
                end
                ST_LOAD_B: begin
                    if (press) b_reg <= sw;
                end
                ST_LOAD_OP: begin
                    if (press) begin
                        sel_reg    <= sw[3:0];
                        bad_op_reg <= (sw[3:0] == 4'hD) || (sw[3:0] == 4'hE);
                    end
                end
                ST_EXEC: begin
                    // ALU has had a full cycle with stable a/b/select here
                    result_reg   <= alu_x;
                    op_count_reg <= op_count_reg + 8'd1;
                end
                ST_SHOW: begin
`ifdef ALU_CHAIN_EN
                    if (press) a_reg <= result_reg;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign a_out    = a_reg;
    assign b_out    = b_reg;
    assign sel_out  = sel_reg;
    assign result   = result_reg;
    assign bad_op   = bad_op_reg;
    assign op_count = op_count_reg;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for alu_input_sequencer. A small behavioural ALU drives
// alu_x from the sequencer's a/b/select outputs. Expected values are
// hand-computed. Build with ALU_CHAIN_EN defined to exercise chaining.
module tb_alu_input_sequencer;

    logic       clk;
    logic       reset;
    logic [7:0] sw;
    logic       enter;
    logic [7:0] alu_x;
    logic [7:0] a_out;
    logic [7:0] b_out;
    logic [3:0] sel_out;
    logic [7:0] result;
    logic [2:0] stage;
    logic       done;
    logic       bad_op;
    logic [7:0] op_count;

    int checks   = 0;
    int failures = 0;

    alu_input_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .enter    (enter),
        .alu_x    (alu_x),
        .a_out    (a_out),
        .b_out    (b_out),
        .sel_out  (sel_out),
        .result   (result),
        .stage    (stage),
        .done     (done),
        .bad_op   (bad_op),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple ALU model: 0 add, 1 pass a, 2 pass b, F all ones, others 8'h81
    always_comb begin
        case (sel_out)
            4'h0:    alu_x = a_out + b_out;
            4'h1:    alu_x = a_out;
            4'h2:    alu_x = b_out;
            4'hF:    alu_x = 8'hFF;
            default: alu_x = 8'h81;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One low cycle so the edge detector re-arms, then one press cycle
    task automatic press(input logic [7:0] v);
        enter = 1'b0;
        tick();
        sw    = v;
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        enter = 1'b0;
        sw    = 8'h00;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_stage", {5'd0, stage}, 8'd0);
        check("rst_done", {7'd0, done}, 8'd0);
        check("rst_a", a_out, 8'h00);
        check("rst_b", b_out, 8'h00);
        check("rst_sel", {4'd0, sel_out}, 8'h00);
        check("rst_result", result, 8'h00);
        check("rst_bad", {7'd0, bad_op}, 8'd0);
        check("rst_count", op_count, 8'h00);

        // Pass 1: A=35 B=0C op=1 -> result 35
        press(8'h35);
        check("p1_stage1", {5'd0, stage}, 8'd1);
        check("p1_a", a_out, 8'h35);
        press(8'h0C);
        check("p1_stage2", {5'd0, stage}, 8'd2);
        check("p1_b", b_out, 8'h0C);
        press(8'h01);
        check("p1_stage3", {5'd0, stage}, 8'd3);
        check("p1_sel", {4'd0, sel_out}, 8'h01);
        check("p1_res_early", result, 8'h00);
        check("p1_done_early", {7'd0, done}, 8'd0);
        tick();
        check("p1_stage4", {5'd0, stage}, 8'd4);
        check("p1_result", result, 8'h35);
        check("p1_count", op_count, 8'h01);
        check("p1_done", {7'd0, done}, 8'd1);
        $display("txn pass1 a=%h b=%h sel=%h result=%h count=%0d", a_out, b_out, sel_out, result, op_count);
        // SHOW holds without a press
        tick();
        tick();
        check("p1_show_hold", {5'd0, stage}, 8'd4);

        // Leave SHOW
        press(8'h77);
`ifdef ALU_CHAIN_EN
        check("p1_leave_stage", {5'd0, stage}, 8'd1);
        check("p1_leave_a", a_out, 8'h35);
`else
        check("p1_leave_stage", {5'd0, stage}, 8'd0);
        // Get back to LOAD_A state in both builds via reset is not needed here
`endif

`ifdef ALU_CHAIN_EN
        // Go back to LOAD_A for the held-button test
        reset = 1'b1;
        tick();
        reset = 1'b0;
        press(8'h35);
        press(8'h0C);
        press(8'h01);
        tick();
        press(8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        press(8'h35);
        press(8'h0C);
        press(8'h01);
        tick();
`endif

`ifdef ALU_CHAIN_EN
        // Chain build re-entered LOAD_A via reset; count restarted at 1 after the pass
        press(8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
`endif

        // Held enter in LOAD_A: one advance only, sw sampled on the press cycle
        enter = 1'b0;
        tick();
        sw    = 8'hAA;
        enter = 1'b1;
        tick();
        sw    = 8'h55;
        for (int i = 0; i < 9; i++) tick();
        enter = 1'b0;
        check("hold_stage", {5'd0, stage}, 8'd1);
        check("hold_a", a_out, 8'hAA);
`ifdef ALU_CHAIN_EN
        check("hold_b", b_out, 8'h00);
`else
        check("hold_b", b_out, 8'h0C);
`endif
        $display("txn hold a=%h stage=%0d", a_out, stage);

        // Bad opcode D -> ALU default 81
        press(8'h0C);
        press(8'h0D);
        check("bad_stage3", {5'd0, stage}, 8'd3);
        check("bad_flag", {7'd0, bad_op}, 8'd1);
        tick();
        check("bad_result", result, 8'h81);
`ifdef ALU_CHAIN_EN
        check("bad_count", op_count, 8'h01);
`else
        check("bad_count", op_count, 8'h02);
`endif
        $display("txn bad a=%h b=%h sel=%h result=%h bad=%0d", a_out, b_out, sel_out, result, bad_op);

        // Following pass with opcode F clears bad_op
        press(8'h00);
`ifdef ALU_CHAIN_EN
        check("bad_leave_a", a_out, 8'h81);
`else
        press(8'h12);
`endif
        press(8'h03);
        press(8'h0F);
        check("f_flag", {7'd0, bad_op}, 8'd0);
        tick();
        check("f_result", result, 8'hFF);
        $display("txn opF a=%h b=%h sel=%h result=%h bad=%0d", a_out, b_out, sel_out, result, bad_op);
        press(8'h00);

        // Reset asserted during EXEC: no capture, no count
        reset = 1'b1;
        tick();
        reset = 1'b0;
        press(8'h12);
        press(8'h34);
        press(8'h01);
        check("rx_stage3", {5'd0, stage}, 8'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rx_stage", {5'd0, stage}, 8'd0);
        check("rx_result", result, 8'h00);
        check("rx_count", op_count, 8'h00);
        $display("txn reset_in_exec stage=%0d result=%h count=%0d", stage, result, op_count);

        // Chain behaviour: A=12 op=1, press in SHOW
        press(8'h12);
        press(8'h34);
        press(8'h01);
        tick();
        check("ch_result", result, 8'h12);
        press(8'h99);
`ifdef ALU_CHAIN_EN
        check("ch_stage", {5'd0, stage}, 8'd1);
`else
        check("ch_stage", {5'd0, stage}, 8'd0);
`endif
        check("ch_a", a_out, 8'h12);
        $display("txn chain stage=%0d a=%h", stage, a_out);

        // op_count wrap: 256 operations from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 256; n++) begin
            if (stage == 3'd0) press(n[7:0]);
            press(8'h01);
            press(8'h00);
            tick();
            $display("txn wrap n=%0d result=%h count=%h", n, result, op_count);
            if (n == 254) check("wrap_ff", op_count, 8'hFF);
            press(8'h00);
        end
        check("wrap_00", op_count, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
